// File: rtl/traffic_cmd.sv
// Front-panel command stage: synchronizes and debounces SEND/GO, latches switch fields into the
// per-light programming bus, and tracks run state and which light/colour slots were programmed.
module traffic_cmd #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_send,
    input  logic       i_btn_go,
    input  logic [7:0] i_sw,
    output logic       o_inst_send,
    output logic [1:0] o_traffic_sel,
    output logic       o_color_sel,
    output logic       o_start_color,
    output logic [3:0] o_input_time,
    output logic       o_is_running,
    output logic [7:0] o_cfg_mask,
    output logic       o_send_rejected
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned BTN_SEND = 0;
    localparam int unsigned BTN_GO   = 1;

    typedef enum logic {
        StStopped,
        StRunning
    } state_e;

    state_e           r_state;
    logic [1:0]       r_btn_meta;
    logic [1:0]       r_btn_sync;
    logic [7:0]       r_sw_meta;
    logic [7:0]       r_sw_sync;
    logic [1:0]       r_db;
    logic [1:0]       r_db_prev;
    logic [CNT_W-1:0] r_cnt [2];

    logic [1:0]       w_press;
    logic [2:0]       w_slot;

    assign w_press      = r_db & ~r_db_prev;
    assign w_slot       = {r_sw_sync[1:0], r_sw_sync[2]};
    assign o_is_running = (r_state == StRunning);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_btn_meta <= {i_btn_go, i_btn_send};
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= i_sw;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // A level change needs DEBOUNCE_CYCLES consecutive differing samples; any match restarts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_db      <= '0;
            r_db_prev <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_db_prev <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_btn_sync[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_db[i]  <= ~r_db[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Send is judged against the pre-toggle state when both buttons fire together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= StStopped;
            o_inst_send     <= 1'b0;
            o_send_rejected <= 1'b0;
            o_traffic_sel   <= '0;
            o_color_sel     <= 1'b0;
            o_start_color   <= 1'b0;
            o_input_time    <= '0;
            o_cfg_mask      <= '0;
        end else begin
            o_inst_send     <= 1'b0;
            o_send_rejected <= 1'b0;
            if (w_press[BTN_SEND]) begin
                if (r_state == StStopped) begin
                    o_inst_send        <= 1'b1;
                    o_traffic_sel      <= r_sw_sync[1:0];
                    o_color_sel        <= r_sw_sync[2];
                    o_start_color      <= r_sw_sync[3];
                    o_input_time       <= r_sw_sync[7:4];
                    o_cfg_mask[w_slot] <= 1'b1;
                end else begin
                    o_send_rejected <= 1'b1;
                end
            end
            if (w_press[BTN_GO]) begin
                r_state <= (r_state == StStopped) ? StRunning : StStopped;
            end
        end
    end

endmodule

// File: tb/tb_traffic_cmd.sv
// Scoreboarded bench for traffic_cmd with a short debounce window; expected programming
// transactions are queued as SEND presses are driven and popped on each inst_send pulse.
module tb_traffic_cmd;

    localparam int unsigned DB = 4;

    typedef struct packed {
        logic [1:0] sel;
        logic       color;
        logic       start;
        logic [3:0] t;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       btn_send;
    logic       btn_go;
    logic [7:0] sw;
    logic       inst_send;
    logic [1:0] traffic_sel;
    logic       color_sel;
    logic       start_color;
    logic [3:0] input_time;
    logic       is_running;
    logic [7:0] cfg_mask;
    logic       send_rejected;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests;
    int   n_fail;
    int   n_sends;
    int   n_rej;

    traffic_cmd #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (3)
    ) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_btn_send     (btn_send),
        .i_btn_go       (btn_go),
        .i_sw           (sw),
        .o_inst_send    (inst_send),
        .o_traffic_sel  (traffic_sel),
        .o_color_sel    (color_sel),
        .o_start_color  (start_color),
        .o_input_time   (input_time),
        .o_is_running   (is_running),
        .o_cfg_mask     (cfg_mask),
        .o_send_rejected(send_rejected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t fields_of(input logic [7:0] s);
        exp_t e;
        e.sel   = s[1:0];
        e.color = s[2];
        e.start = s[3];
        e.t     = s[7:4];
        return e;
    endfunction

    // Full press: rise, hold until well past the debounce, release and let the release settle.
    task automatic press_send();
        btn_send = 1'b1;
        tick(DB + 6);
        btn_send = 1'b0;
        tick(DB + 6);
    endtask

    task automatic press_go();
        btn_go = 1'b1;
        tick(DB + 6);
        btn_go = 1'b0;
        tick(DB + 6);
    endtask

    task automatic check_fields(input string tag, input exp_t e);
        check({tag, "_sel"}, 32'(traffic_sel), 32'(e.sel));
        check({tag, "_color"}, 32'(color_sel), 32'(e.color));
        check({tag, "_start"}, 32'(start_color), 32'(e.start));
        check({tag, "_time"}, 32'(input_time), 32'(e.t));
    endtask

    always @(negedge clk) begin
        if (!rst && send_rejected) n_rej++;
        if (!rst && inst_send) begin
            n_sends++;
            if (exp_q.size() == 0) begin
                check("unexpected_send", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_fields("sb", mon_e);
                check("sb_mask_bit", 32'(cfg_mask[{mon_e.sel, mon_e.color}]), 32'd1);
            end
        end
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        n_sends  = 0;
        n_rej    = 0;
        rst      = 1'b1;
        btn_send = 1'b0;
        btn_go   = 1'b0;
        sw       = 8'h00;
        tick(3);
        check("rst_running", 32'(is_running), 32'd0);
        check("rst_mask", 32'(cfg_mask), 32'd0);
        check("rst_send", 32'(inst_send), 32'd0);
        check("rst_rej", 32'(send_rejected), 32'd0);
        check_fields("rst", '0);
        rst = 1'b0;

        // Long hold yields one pulse exactly 7 edges after the rise.
        sw = 8'b1010_1101;
        tick(3);
        exp_q.push_back(fields_of(sw));
        btn_send = 1'b1;
        tick(6);
        check("t1_early", 32'(inst_send), 32'd0);
        tick(1);
        check("t1_pulse", 32'(inst_send), 32'd1);
        tick(1);
        check("t1_one_cycle", 32'(inst_send), 32'd0);
        tick(12);
        btn_send = 1'b0;
        tick(DB + 6);
        check("t1_count", 32'(n_sends), 32'd1);
        check_fields("t1", fields_of(8'b1010_1101));
        check("t1_mask", 32'(cfg_mask), 32'h08);

        // Bounces shorter than the window are rejected.
        sw = 8'h52;
        tick(3);
        repeat (5) begin
            btn_send = 1'b1;
            tick(3);
            btn_send = 1'b0;
            tick(1);
        end
        tick(DB + 6);
        check("t2_count", 32'(n_sends), 32'd1);
        check("t2_mask", 32'(cfg_mask), 32'h08);
        check_fields("t2", fields_of(8'b1010_1101));

        // GO latency, rejected SEND while running, then stop.
        btn_go = 1'b1;
        tick(6);
        check("t3_go_early", 32'(is_running), 32'd0);
        tick(1);
        check("t3_running", 32'(is_running), 32'd1);
        btn_go = 1'b0;
        tick(DB + 6);
        press_send();
        check("t3_rej_count", 32'(n_rej), 32'd1);
        check("t3_no_send", 32'(n_sends), 32'd1);
        check_fields("t3", fields_of(8'b1010_1101));
        press_go();
        check("t3_stopped", 32'(is_running), 32'd0);

        // Simultaneous SEND+GO from STOPPED: issued and running on the same edge.
        sw = 8'h31;
        tick(3);
        exp_q.push_back(fields_of(sw));
        btn_send = 1'b1;
        btn_go   = 1'b1;
        tick(6);
        check("t4_send_early", 32'(inst_send), 32'd0);
        check("t4_run_early", 32'(is_running), 32'd0);
        tick(1);
        check("t4_send", 32'(inst_send), 32'd1);
        check("t4_run", 32'(is_running), 32'd1);
        btn_send = 1'b0;
        btn_go   = 1'b0;
        tick(DB + 6);
        check_fields("t4", fields_of(8'h31));
        check("t4_mask", 32'(cfg_mask), 32'h0c);
        check("t4_rej_count", 32'(n_rej), 32'd1);
        press_go();
        check("t4_stopped", 32'(is_running), 32'd0);

        // Program every slot, including a zero time.
        for (int s = 0; s < 8; s++) begin
            sw = {4'(s * 3), 1'(s >> 1), 1'(s), 2'(s >> 1)};
            tick(3);
            exp_q.push_back(fields_of(sw));
            press_send();
        end
        check("t5_mask", 32'(cfg_mask), 32'hff);
        check("t5_count", 32'(n_sends), 32'd10);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while running with GO held; the held GO reads as a fresh press afterwards.
        btn_go = 1'b1;
        tick(DB + 3);
        check("t5_running", 32'(is_running), 32'd1);
        rst = 1'b1;
        tick(1);
        check("t5_rst_running", 32'(is_running), 32'd0);
        check("t5_rst_mask", 32'(cfg_mask), 32'd0);
        check("t5_rst_send", 32'(inst_send), 32'd0);
        check_fields("t5_rst", '0);
        tick(2);
        rst = 1'b0;
        tick(6);
        check("t5_rerun_early", 32'(is_running), 32'd0);
        tick(1);
        check("t5_rerun", 32'(is_running), 32'd1);
        btn_go = 1'b0;
        tick(DB + 6);
        check("t5_final_mask", 32'(cfg_mask), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
